// File: rtl/pool_pkg.sv
// Shared constants, width helpers and FSM states for the average-pooling engine.
// The rounding option is selected by AVG_POOL_ROUND_EN in avg_pool_stream.
package pool_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_IMG_W  = 28;
    localparam int DEF_IMG_H  = 28;
    localparam int DEF_POOL   = 2;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int sum_w(input int dw, input int pool);
        return dw + 2 * clog2(pool);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pool_state_e;

endpackage

// File: rtl/pool_line_buffer.sv
// Per-column-group partial window sums for one band of POOL rows.
// Combinational read, synchronous write, no reset on the storage.
module pool_line_buffer
    import pool_pkg::*;
#(
    parameter int DEPTH = 14,
    parameter int WIDTH = 10,
    parameter int AW    = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rd_data_o = mem_q[addr_i];

    // Write the updated partial sum back to the same group slot.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/avg_pool_stream.sv
// Streaming POOL x POOL average pooling over a raster-scan frame.
// Define AVG_POOL_ROUND_EN for round-half-up results instead of truncation.
module avg_pool_stream
    import pool_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int POOL   = DEF_POOL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pool_en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              pool_done
);

    localparam int L      = clog2(POOL);
    localparam int SH     = 2 * L;
    localparam int SUM_W  = sum_w(DATA_W, POOL);
    localparam int GROUPS = IMG_W / POOL;
    localparam int COL_W  = clog2(IMG_W);
    localparam int ROW_W  = clog2(IMG_H);
    localparam int AW     = (clog2(GROUPS) > 0) ? clog2(GROUPS) : 1;

    localparam logic [L-1:0]     PH_LAST = L'(POOL - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    if (!is_pow2(POOL) || POOL < 2 || POOL > 8) begin : g_bad_pool
        $error("POOL must be a power of two in 2..8");
    end
    if (IMG_W % POOL != 0) begin : g_bad_w
        $error("IMG_W must be a multiple of POOL");
    end
    if (IMG_H % POOL != 0) begin : g_bad_h
        $error("IMG_H must be a multiple of POOL");
    end

    pool_state_e       state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [SUM_W-1:0]  hsum_q, hsum_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              pool_done_q, pool_done_d;

    logic              accept;
    logic              out_fire;
    logic              out_load;
    logic              col_end;
    logic              row_end;
    logic              grp_first;
    logic              grp_end;
    logic              band_first;
    logic              band_last;
    logic [SUM_W-1:0]  s_ext;
    logic [SUM_W-1:0]  grp_sum;
    logic [SUM_W-1:0]  lb_rd;
    logic [SUM_W-1:0]  lb_wr;
    logic [SUM_W-1:0]  win_sum;
    logic [SUM_W-1:0]  win_adj;
    logic [DATA_W-1:0] result;
    logic [AW-1:0]     lb_addr;
    logic              lb_we;

    assign s_ready   = (state_q == RUN) && (!m_valid_q || m_ready);
    assign accept    = s_valid && s_ready;
    assign out_fire  = m_valid_q && m_ready;
    assign busy      = (state_q != IDLE);
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign pool_done = pool_done_q;

    assign col_end    = (col_q == COL_MAX);
    assign row_end    = (row_q == ROW_MAX);
    assign grp_first  = (col_q[L-1:0] == '0);
    assign grp_end    = (col_q[L-1:0] == PH_LAST);
    assign band_first = (row_q[L-1:0] == '0);
    assign band_last  = (row_q[L-1:0] == PH_LAST);

    assign s_ext   = SUM_W'(s_data);
    assign grp_sum = hsum_q + s_ext;
    assign lb_addr = AW'(col_q >> L);
    assign lb_we   = accept && grp_end && !band_last;
    assign lb_wr   = band_first ? grp_sum : lb_rd + grp_sum;
    assign win_sum = lb_rd + grp_sum;

`ifdef AVG_POOL_ROUND_EN
    assign win_adj = win_sum + SUM_W'(1 << (SH - 1));
`else
    assign win_adj = win_sum;
`endif

    assign result   = DATA_W'(win_adj >> SH);
    assign out_load = accept && grp_end && band_last;

    pool_line_buffer #(
        .DEPTH (GROUPS),
        .WIDTH (SUM_W),
        .AW    (AW)
    ) u_lbuf (
        .clk       (clk),
        .addr_i    (lb_addr),
        .rd_data_o (lb_rd),
        .wr_en_i   (lb_we),
        .wr_data_i (lb_wr)
    );

    // Frame sequencing and raster position tracking.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        pool_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pool_en) begin
                    state_d = RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (col_end) begin
                        col_d = '0;
                        row_d = row_end ? '0 : row_q + ROW_W'(1);
                        if (row_end) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_fire && m_last_q) begin
                    state_d     = IDLE;
                    pool_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Horizontal group accumulation and the output holding register.
    always_comb begin
        hsum_d    = hsum_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        if (accept) begin
            hsum_d = grp_first ? s_ext : hsum_q + s_ext;
        end
        if (out_fire) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end
        if (out_load) begin
            m_valid_d = 1'b1;
            m_data_d  = result;
            m_last_d  = col_end && row_end;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            hsum_q      <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            pool_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            hsum_q      <= hsum_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            pool_done_q <= pool_done_d;
        end
    end

endmodule

// File: doc/avg_pool_stream.md
Name: avg_pool_stream

Overview:
- Streaming KxK average-pooling engine for the digit-recognition datapath.
- Accepts one raster-scan pixel per handshake beat from the frame buffer and emits one averaged pixel per completed POOL x POOL window over a valid/ready stream.
- Handles a full IMG_W x IMG_H frame per start pulse and signals completion, replacing the single-window combinational averager with a buffered, back-pressurable, frame-sequenced block.

Parameters:
- DATA_W, 8: pixel width in and out.
- IMG_W, 28: input frame width in pixels; must be a multiple of POOL.
- IMG_H, 28: input frame height in pixels; must be a multiple of POOL.
- POOL, 2: window edge; power of two, 2..8.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- pool_en  in  1  start pulse; sampled only in IDLE.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel accepted when s_valid && s_ready.
- s_data  in  DATA_W  input pixel, raster order.
- m_valid  out  1  pooled pixel valid.
- m_ready  in  1  downstream accepts when m_valid && m_ready.
- m_data  out  DATA_W  pooled pixel.
- m_last  out  1  high with the final pooled pixel of the frame.
- busy  out  1  high in RUN and DRAIN.
- pool_done  out  1  one-cycle pulse after the final output is accepted.

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; col/row counters 0; s_ready, m_valid, m_last, busy, pool_done = 0; m_data = 0. Line-buffer contents don't-care. Reset mid-frame abandons the frame; no pool_done.
- Widths: L = log2(POOL); SUM_W = DATA_W + 2L. Sums never wrap. Result = sum >> 2L, always fits DATA_W.
- FSM:
  - IDLE: pool_en=1 -> RUN, clearing counters. s_ready=0.
  - RUN: s_ready = !m_valid || m_ready. Each accepted beat advances col (0..IMG_W-1), wrapping into row (0..IMG_H-1). Accepting the last pixel (col=IMG_W-1, row=IMG_H-1) -> DRAIN.
  - DRAIN: s_ready=0. When the final output is accepted -> IDLE, with pool_done=1 for one cycle. pool_done coincides with busy=0.
  - pool_en in RUN or DRAIN is ignored.
- Horizontal accumulator hsum:
  - Loaded with s_data at col%POOL==0; otherwise accumulates.
  - At col%POOL==POOL-1 the group total g = hsum + s_data is formed.
- Line buffer, IMG_W/POOL entries of SUM_W, indexed by col/POOL:
  - row%POOL==0: entry written with g; prior contents are not read.
  - Intermediate rows: entry = entry + g.
  - row%POOL==POOL-1: window sum = entry + g; result registered onto m_data with m_valid=1 on the next clock. Latency is 1 cycle from the completing input beat.
- m_last = 1 together with the result from the final window of the frame.
- Output register holds m_data, m_last, m_valid stable until accepted. A new result may load in the same cycle the old one is accepted, giving full throughput.
- Input beats with s_ready=0 are not consumed; counters hold.
- Elaboration error if IMG_W%POOL or IMG_H%POOL is non-zero, or POOL is not a power of two.

Optional Feature:
- Macro: AVG_POOL_ROUND_EN.
- Defined: result = (sum + 2^(2L-1)) >> 2L, round-half-up. No overflow is possible, since max sum + half < 2^SUM_W.
- Undefined: truncating result = sum >> 2L.

Decomposition:
- Package pool_pkg: clog2 function, SUM_W derivation, FSM state enum (IDLE, RUN, DRAIN), default image and pool constants.
- Sub-module pool_line_buffer: single-port-per-cycle array of IMG_W/POOL x SUM_W entries, combinational read and synchronous write, reset-free.

Test Plan:
- 4x4 frame, POOL=2, pixels 0..15 raster, m_ready=1 -> outputs 2,4,10,12 (trunc) or 3,5,11,13 (round); m_last on 4th; pool_done one cycle after it.
- Single 2x2 window 1,1,2,2 -> m_data=1 without AVG_POOL_ROUND_EN, 2 with it. All-255 28x28 frame -> 196 outputs of 255, no overflow.
- Random m_ready (50%) on a 28x28 frame -> s_ready drops only while m_valid && !m_ready; output sequence matches the reference model; m_data stable while stalled.
- pool_en pulsed again mid-RUN -> ignored; frame completes normally with exactly 196 outputs.
- rst_n=0 for one cycle after 30 input beats, then pool_en -> all outputs 0 during reset; new frame pools correctly with no stale line-buffer data.
- POOL=4, IMG_W=IMG_H=8, constant pixel 7 -> 4 outputs of 7; beats gapped by s_valid=0 -> same results, counters hold during gaps.
